// File: rtl/cache_pkg.sv
// Types and address helpers shared by the L1 instruction cache and its line fill unit.
package cache_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DONE
  } fill_state_t;

  // Byte address of the first word of the line holding addr.
  function automatic logic [WORD_W-1:0] line_base(input logic [WORD_W-1:0] addr,
                                                  input int unsigned line_words);
    logic [WORD_W-1:0] mask;
    mask = WORD_W'(line_words * 4) - 1;
    return addr & ~mask;
  endfunction

  // Word slot of addr inside its line; callers truncate to their index width.
  function automatic logic [WORD_W-1:0] word_idx(input logic [WORD_W-1:0] addr,
                                                 input int unsigned line_words);
    return (addr >> 2) & WORD_W'(line_words - 1);
  endfunction

endpackage

// File: rtl/line_fill_unit.sv
// Miss-service engine: reads one cache line from main memory, critical word first,
// forwards the missed word early and hands the assembled line to the cache.
module line_fill_unit
  import cache_pkg::*;
#(
  parameter int LINE_WORDS  = 4,
  parameter int WAIT_CYCLES = 2,
  parameter int CWF         = 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         req_i,
  input  logic [WORD_W-1:0]            req_addr_i,
  input  logic                         flush_i,
  output logic                         busy_o,
  output logic                         crit_valid_o,
  output logic [WORD_W-1:0]            crit_data_o,
  output logic                         fill_valid_o,
  output logic [WORD_W-1:0]            fill_addr_o,
  output logic [WORD_W*LINE_WORDS-1:0] fill_data_o,
  output logic                         mem_ce_n,
  output logic                         mem_oe_n,
  output logic [WORD_W-1:0]            mem_addr_o,
  input  logic [WORD_W-1:0]            mem_data_i
);

  localparam int IDX_W = $clog2(LINE_WORDS);
  localparam int WC_W  = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  typedef logic [IDX_W-1:0]                         idx_t;
  typedef logic [LINE_WORDS-1:0][WORD_W-1:0]        line_t;

  fill_state_t       state_q, state_d;
  logic [WORD_W-1:0] base_q, base_d;
  idx_t              crit_idx_q, crit_idx_d;
  idx_t              k_q, k_d;
  logic [WC_W-1:0]   wcnt_q, wcnt_d;
  line_t             line_q, line_d;
  logic              crit_valid_q, crit_valid_d;
  logic [WORD_W-1:0] crit_data_q, crit_data_d;
  logic [WORD_W-1:0] fill_addr_q, fill_addr_d;
  line_t             fill_data_q, fill_data_d;

  idx_t idx;
  logic capture;

  // The index is IDX_W bits wide, so the critical-word-first wrap stays inside the line.
  assign idx     = (CWF != 0) ? idx_t'(crit_idx_q + k_q) : k_q;
  assign capture = (state_q == READ) && (wcnt_q == WC_W'(WAIT_CYCLES));

  // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    crit_idx_d   = crit_idx_q;
    k_d          = k_q;
    wcnt_d       = wcnt_q;
    line_d       = line_q;
    crit_valid_d = 1'b0;
    crit_data_d  = crit_data_q;
    fill_addr_d  = fill_addr_q;
    fill_data_d  = fill_data_q;

    case (state_q)
      IDLE: begin
        if (req_i && !flush_i) begin
          state_d    = READ;
          base_d     = line_base(req_addr_i, LINE_WORDS);
          crit_idx_d = idx_t'(word_idx(req_addr_i, LINE_WORDS));
          k_d        = '0;
          wcnt_d     = '0;
        end
      end

      READ: begin
        if (flush_i) begin
          state_d = IDLE;
        end else if (capture) begin
          line_d[idx] = mem_data_i;
          if (idx == crit_idx_q) begin
            crit_valid_d = 1'b1;
            crit_data_d  = mem_data_i;
          end
          if (k_q == idx_t'(LINE_WORDS - 1)) begin
            // The output copy is only updated here so it holds steady through the next fill.
            state_d     = DONE;
            fill_addr_d = base_q;
            fill_data_d = line_d;
          end else begin
            k_d    = k_q + idx_t'(1);
            wcnt_d = '0;
          end
        end else begin
          wcnt_d = wcnt_q + WC_W'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      base_q       <= '0;
      crit_idx_q   <= '0;
      k_q          <= '0;
      wcnt_q       <= '0;
      crit_valid_q <= 1'b0;
      crit_data_q  <= '0;
      fill_addr_q  <= '0;
      fill_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      crit_idx_q   <= crit_idx_d;
      k_q          <= k_d;
      wcnt_q       <= wcnt_d;
      crit_valid_q <= crit_valid_d;
      crit_data_q  <= crit_data_d;
      fill_addr_q  <= fill_addr_d;
      fill_data_q  <= fill_data_d;
    end
  end

  // NOTE: the assembly buffer is pure datapath; every slot is rewritten before it is published, so it carries no reset.
  always_ff @(posedge clk) begin
    line_q <= line_d;
  end

  assign busy_o       = (state_q != IDLE);
  assign fill_valid_o = (state_q == DONE);
  assign crit_valid_o = crit_valid_q;
  assign crit_data_o  = crit_data_q;
  assign fill_addr_o  = fill_addr_q;
  assign fill_data_o  = fill_data_q;
  assign mem_ce_n     = (state_q != READ);
  assign mem_oe_n     = (state_q != READ);
  assign mem_addr_o   = (state_q == READ) ? (base_q | (WORD_W'(idx) << 2)) : '0;

endmodule
